// File: rtl/matrix_result_serializer.sv
// Serializes a captured matrix of results into bytes over a valid/ready stream, element 0 first, LSB first.
// Optional trailing XOR checksum byte when MATRIX_SER_CKSUM_EN is defined.
module matrix_result_serializer #(
  parameter int NUM_ELEM = 9,
  parameter int ELEM_W   = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [NUM_ELEM*ELEM_W-1:0]   c_flat,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         overflow_err,
  output logic [1:0]                   dbg_state_o
);

  localparam int BPE = (ELEM_W + 7) / 8;
  localparam int EW  = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1;

  // Stream handshake: a byte moves on each rising edge where out_valid and
  // out_ready are both 1; out_valid never depends on out_ready.
`ifdef MATRIX_SER_CKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CKSUM = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t                       state_q, state_d;
  logic [NUM_ELEM*ELEM_W-1:0]   shadow_q, shadow_d;
  logic [EW-1:0]                elem_q, elem_d;
  logic [BW-1:0]                byte_q, byte_d;
  logic                         ovf_q, ovf_d;
`ifdef MATRIX_SER_CKSUM_EN
  logic [7:0]                   cksum_q, cksum_d;
`endif

  logic [ELEM_W-1:0]            elem_sel;
  logic [BPE*8-1:0]             elem_pad;
  logic [7:0]                   byte_sel;
  logic                         fire;
  logic                         last_send;
  logic                         final_xfer;
  logic                         accept;

  always_comb begin
    elem_sel = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (elem_q == EW'(i)) elem_sel = shadow_q[i*ELEM_W +: ELEM_W];
    end
    elem_pad = '0;
    elem_pad[ELEM_W-1:0] = elem_sel;
    byte_sel = '0;
    for (int j = 0; j < BPE; j++) begin
      if (byte_q == BW'(j)) byte_sel = elem_pad[j*8 +: 8];
    end
  end

  assign out_valid   = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign overflow_err = ovf_q;
  assign dbg_state_o = state_q;
  assign fire        = out_valid & out_ready;
  assign last_send   = (state_q == SEND) && (elem_q == EW'(NUM_ELEM-1)) && (byte_q == BW'(BPE-1));

`ifdef MATRIX_SER_CKSUM_EN
  assign final_xfer = fire && (state_q == CKSUM);
  assign out_data   = (state_q == CKSUM) ? cksum_q : ((state_q == SEND) ? byte_sel : 8'h00);
`else
  assign final_xfer = fire && last_send;
  assign out_data   = (state_q == SEND) ? byte_sel : 8'h00;
`endif

  // A load is taken when idle or on the edge that completes the frame.
  assign accept = load && ((state_q == IDLE) || final_xfer);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    elem_d   = elem_q;
    byte_d   = byte_q;
    ovf_d    = ovf_q | (load & busy & ~final_xfer);
`ifdef MATRIX_SER_CKSUM_EN
    cksum_d  = cksum_q;
`endif
    if (accept) begin
      state_d  = SEND;
      shadow_d = c_flat;
      elem_d   = '0;
      byte_d   = '0;
`ifdef MATRIX_SER_CKSUM_EN
      cksum_d  = 8'h00;
`endif
    end else begin
      case (state_q)
        SEND: begin
          if (fire) begin
`ifdef MATRIX_SER_CKSUM_EN
            cksum_d = cksum_q ^ byte_sel;
`endif
            if (last_send) begin
`ifdef MATRIX_SER_CKSUM_EN
              state_d = CKSUM;
`else
              state_d = IDLE;
`endif
              elem_d = '0;
              byte_d = '0;
            end else if (byte_q == BW'(BPE-1)) begin
              byte_d = '0;
              elem_d = elem_q + EW'(1);
            end else begin
              byte_d = byte_q + BW'(1);
            end
          end
        end
`ifdef MATRIX_SER_CKSUM_EN
        CKSUM: begin
          if (fire) state_d = IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      elem_q   <= '0;
      byte_q   <= '0;
      ovf_q    <= 1'b0;
`ifdef MATRIX_SER_CKSUM_EN
      cksum_q  <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      elem_q   <= elem_d;
      byte_q   <= byte_d;
      ovf_q    <= ovf_d;
`ifdef MATRIX_SER_CKSUM_EN
      cksum_q  <= cksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: table of single-element frames plus
// hand sequences for stall, dropped load, back-to-back load and mid-frame reset.
module tb_matrix_result_serializer;

  localparam int NUM_ELEM = 9;
  localparam int ELEM_W   = 18;
  localparam int DATA_LEN = 27;
`ifdef MATRIX_SER_CKSUM_EN
  localparam int FRAME_LEN = 28;
`else
  localparam int FRAME_LEN = 27;
`endif

  logic                       clk;
  logic                       rst_n;
  logic                       load;
  logic [NUM_ELEM*ELEM_W-1:0] c_flat;
  logic [7:0]                 out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;
  logic                       overflow_err;
  logic [1:0]                 dbg_state;

  matrix_result_serializer #(.NUM_ELEM(NUM_ELEM), .ELEM_W(ELEM_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .c_flat       (c_flat),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overflow_err (overflow_err),
    .dbg_state_o  (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int          elem;
    logic [17:0] val;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
  } vec_t;

  vec_t vecs[5];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // scoreboard: a byte is counted at the negedge preceding the edge that transfers it
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL extra_byte: got %h expected no byte", out_data);
      end else begin
        chk("stream_byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_frame(input int elem, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    for (int k = 0; k < DATA_LEN; k++) begin
      if (k == elem*3)        exp_q.push_back(b0);
      else if (k == elem*3+1) exp_q.push_back(b1);
      else if (k == elem*3+2) exp_q.push_back(b2);
      else                    exp_q.push_back(8'h00);
    end
`ifdef MATRIX_SER_CKSUM_EN
    exp_q.push_back(b0 ^ b1 ^ b2);
`endif
  endtask

  function automatic logic [NUM_ELEM*ELEM_W-1:0] mk_c(input int elem, input logic [17:0] val);
    logic [NUM_ELEM*ELEM_W-1:0] c;
    c = '0;
    c[elem*ELEM_W +: ELEM_W] = val;
    return c;
  endfunction

  // leaves the bench at posedge+1 of the accepting edge; c_flat is then scrambled
  task automatic do_load(input logic [NUM_ELEM*ELEM_W-1:0] c);
    @(posedge clk); #1;
    c_flat = c;
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
    c_flat = ~c;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got busy=1 expected busy=0", name);
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [NUM_ELEM*ELEM_W-1:0] cb;

    vecs[0] = '{0, 18'h12345, 8'h45, 8'h23, 8'h01};
    vecs[1] = '{0, 18'h3FFFF, 8'hFF, 8'hFF, 8'h03};
    vecs[2] = '{8, 18'h2A5C3, 8'hC3, 8'hA5, 8'h02};
    vecs[3] = '{4, 18'h00ABC, 8'hBC, 8'h0A, 8'h00};
    vecs[4] = '{3, 18'h10001, 8'h01, 8'h00, 8'h01};

    rst_n = 1'b0; load = 1'b0; c_flat = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // table-driven frames, out_ready held high
    for (int v = 0; v < 5; v++) begin
      push_frame(vecs[v].elem, vecs[v].b0, vecs[v].b1, vecs[v].b2);
      do_load(mk_c(vecs[v].elem, vecs[v].val));
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (busy) cnt++;
        else break;
      end
      chk("busy_cycles", cnt, FRAME_LEN);
      wait_idle("vec");
      chk("vec_ovf", overflow_err, 0);
    end

    // stall during byte 1: ready 1,0,0,1
    push_frame(0, 8'h45, 8'h23, 8'h01);
    do_load(mk_c(0, 18'h12345));
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall_hold0", out_data, 8'h23);
    chk("stall_valid", out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_hold1", out_data, 8'h23);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("stall");

    // dropped load at byte 10
    push_frame(0, 8'h45, 8'h23, 8'h01);
    do_load(mk_c(0, 18'h12345));
    repeat (10) @(posedge clk);
    #1;
    c_flat = mk_c(0, 18'h2FFFF);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    chk("ovf_set", overflow_err, 1);
    wait_idle("ovf");
    chk("ovf_sticky", overflow_err, 1);
    chk("ovf_no_restart", busy, 0);
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", overflow_err, 0);

    // back-to-back load on the final transfer
    push_frame(0, 8'h45, 8'h23, 8'h01);
    push_frame(0, 8'hBC, 8'h0A, 8'h00);
    cb = mk_c(0, 18'h00ABC);
    do_load(mk_c(0, 18'h12345));
    repeat (FRAME_LEN-1) @(posedge clk);
    #1;
    c_flat = cb;
    load = 1'b1;
    @(negedge clk);
    chk("b2b_last_valid", out_valid, 1);
    @(posedge clk); #1;
    load = 1'b0;
    c_flat = ~cb;
    @(negedge clk);
    chk("b2b_no_gap", out_valid, 1);
    chk("b2b_first", out_data, 8'hBC);
    chk("b2b_ovf", overflow_err, 0);
    wait_idle("b2b");
    chk("b2b_ovf_end", overflow_err, 0);

    // reset at byte 5, then load on the first edge after release
    push_frame(0, 8'h45, 8'h23, 8'h01);
    do_load(mk_c(0, 18'h12345));
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", out_data, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    c_flat = mk_c(0, 18'h3FFFF);
    load = 1'b1;
    push_frame(0, 8'hFF, 8'hFF, 8'h03);
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    chk("postrst_busy", busy, 1);
    chk("postrst_first", out_data, 8'hFF);
    wait_idle("postrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
